cell_sweep: RTL and testbench
=============================

CELL_SWEEP -- requirements
Module: cell_sweep

Interface
REQ-001 SHALL have parameter SETTLE, default 0, extra hold cycles per vector before sampling (legal 0..3).
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  in  1  begin sweep; sampled in IDLE/DONE only.
REQ-005 SHALL have port abort  in  1  stop sweep immediately.
REQ-006 SHALL have ports page_lo and page_hi  in  4 each  first and last page of sweep.
REQ-007 SHALL have port page  out  4  page select driven to cell_mux.
REQ-008 SHALL have port vec  out  6  input vector driven to cell_mux.
REQ-009 SHALL have port cell_out  in  8  cell_mux output, combinational from page/vec.
REQ-010 SHALL have ports busy and done  out  1 each  sweep running / sweep completed (sticky).
REQ-011 SHALL have port sig  out  16  accumulated response signature.

Function
REQ-012 SHALL implement FSM IDLE, RUN, DONE; page, vec, busy, done registered.
REQ-013 start in IDLE or DONE SHALL at the same edge load page=page_lo, vec=0, sig=16'h0000, hold counter=0, busy=1, done=0, state RUN.
REQ-014 In RUN each vector SHALL be held SETTLE+1 cycles; cell_out SHALL be sampled into sig only on the last hold cycle.
REQ-015 After sampling: vec SHALL increment; on vec==63, vec SHALL wrap to 0 and page SHALL advance, or the sweep SHALL end if page==page_hi.
REQ-016 Page advance SHALL be modulo 16, so page_lo>page_hi wraps through 15->0 (e.g. 14,15,0,1).
REQ-017 At the edge sampling the final vector: state DONE, busy=0, done=1, page=0, vec=0, sig holds final value.
REQ-018 busy SHALL be high for exactly N_pages*64*(SETTLE+1) cycles per completed sweep.
REQ-019 start during RUN SHALL be ignored; page_lo/page_hi SHALL be sampled only at start.
REQ-020 abort in RUN SHALL at next edge force IDLE, busy=0, done=0, page=0, vec=0, sig retained.
REQ-021 abort and start together SHALL resolve as abort (state IDLE, done=0).
REQ-022 In IDLE and DONE, page and vec SHALL be 0.

Reset
REQ-023 rst_n low SHALL asynchronously force IDLE, page=0, vec=0, busy=0, done=0, sig=0, hold counter=0, including mid-sweep.
REQ-024 After reset release, no sweep SHALL begin without a new start.

Configuration
REQ-025 With CELL_SWEEP_MISR_EN defined, sig SHALL update as MISR: sig_next = (sig>>1) ^ (sig[0] ? 16'hB400 : 0) ^ {8'h00, cell_out}.
REQ-026 Without CELL_SWEEP_MISR_EN, sig SHALL update as additive checksum: sig_next = sig + cell_out, modulo 2^16.

Structure
REQ-027 Shared package cell_pkg SHALL hold the FSM state enum, PAGE_W=4, VEC_W=6, SIG_W=16, and MISR polynomial 16'hB400.
REQ-028 Signature update SHALL live in sub-module cell_sweep_sig (inputs: enable, clear, data; output: sig); the macro selects its update rule.

Verification
REQ-029 Full sweep, lo=0, hi=15, SETTLE=0, cell_out=8'h01, macro off -> busy high 1024 cycles, then done=1, sig=16'h0400.
REQ-030 Single page, lo=hi=5, SETTLE=2, cell_out=8'h00 -> page stays 5 while busy, busy high 192 cycles, sig=16'h0000.
REQ-031 Wrap, lo=14, hi=1, SETTLE=0 -> page sequence 14,15,0,1, each held 64 cycles, busy high 256 cycles.
REQ-032 abort at cycle 100 of a sweep; start pulse during RUN -> start ignored; after abort busy=0, done=0, page=vec=0, sig unchanged at next edge.
REQ-033 rst_n low mid-sweep -> all outputs 0 without a clock edge; start after release runs a normal full sweep.
REQ-034 Macro on, cell_mux model attached, lo=0, hi=0 -> sig equals a bit-exact reference-model MISR over 64 vectors.

Source files
------------

// File: rtl/cell_pkg.sv
// Shared types and widths for the cell_mux sweep engine: FSM state encoding,
// page/vector/signature widths and the MISR feedback polynomial.
package cell_pkg;

    localparam int PAGE_W = 4;
    localparam int VEC_W  = 6;
    localparam int SIG_W  = 16;
    localparam int DATA_W = 8;
    localparam int HOLD_W = 2;

    localparam logic [SIG_W-1:0] MISR_POLY = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/cell_sweep_sig.sv
// Response signature register. Default build: additive checksum modulo 2^16.
// Define CELL_SWEEP_MISR_EN to compact responses with a 16-bit MISR instead.
module cell_sweep_sig
    import cell_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              clear,
    input  logic [DATA_W-1:0] data,
    output logic [SIG_W-1:0]  sig
);

    logic [SIG_W-1:0] r_sig;
    logic [SIG_W-1:0] w_sig_next;
    logic [SIG_W-1:0] w_data_ext;

    assign w_data_ext = {{(SIG_W-DATA_W){1'b0}}, data};

    always_comb begin
        w_sig_next = r_sig;
`ifdef CELL_SWEEP_MISR_EN
        w_sig_next = (r_sig >> 1) ^ (r_sig[0] ? MISR_POLY : '0) ^ w_data_ext;
`else
        w_sig_next = r_sig + w_data_ext;
`endif
    end

    // clear wins over enable so a new sweep always starts from zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig <= '0;
        end else if (clear) begin
            r_sig <= '0;
        end else if (enable) begin
            r_sig <= w_sig_next;
        end
    end

    assign sig = r_sig;

endmodule

// File: rtl/cell_sweep.sv
// Sweeps page/vector space of an external cell_mux and accumulates its responses.
// Optional MISR signature mode selected by CELL_SWEEP_MISR_EN (see cell_sweep_sig).
module cell_sweep
    import cell_pkg::*;
#(
    parameter int unsigned SETTLE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [PAGE_W-1:0] page_lo,
    input  logic [PAGE_W-1:0] page_hi,
    output logic [PAGE_W-1:0] page,
    output logic [VEC_W-1:0]  vec,
    input  logic [DATA_W-1:0] cell_out,
    output logic              busy,
    output logic              done,
    output logic [SIG_W-1:0]  sig,
    output logic [1:0]        o_dbg_state
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_RUN  = ST_RUN;
    localparam logic [1:0] S_DONE = ST_DONE;

    // SETTLE is expected in 0..3 so the hold count fits HOLD_W bits
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SETTLE);

    // Control: start is a level sampled only in IDLE/DONE; busy/done report
    // progress, done stays high until the next start, abort or reset.
    logic [1:0]        r_state;
    logic [PAGE_W-1:0] r_page;
    logic [PAGE_W-1:0] r_page_hi;
    logic [VEC_W-1:0]  r_vec;
    logic [HOLD_W-1:0] r_hold;
    logic              r_busy;
    logic              r_done;

    logic w_running;
    logic w_last_hold;
    logic w_sample;
    logic w_launch;
    logic w_last_vec;

    assign w_running   = (r_state == S_RUN);
    assign w_last_hold = (r_hold == HOLD_LAST);
    assign w_sample    = w_running && !abort && w_last_hold;
    assign w_launch    = !w_running && start && !abort;
    assign w_last_vec  = (r_vec == {VEC_W{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_page    <= '0;
            r_page_hi <= '0;
            r_vec     <= '0;
            r_hold    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else if (abort) begin
            r_state <= S_IDLE;
            r_page  <= '0;
            r_vec   <= '0;
            r_hold  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (!w_last_hold) begin
                        r_hold <= r_hold + 1'b1;
                    end else begin
                        r_hold <= '0;
                        if (!w_last_vec) begin
                            r_vec <= r_vec + 1'b1;
                        end else if (r_page == r_page_hi) begin
                            r_state <= S_DONE;
                            r_page  <= '0;
                            r_vec   <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            // modulo-16 advance lets lo > hi wrap through 15 -> 0
                            r_page <= r_page + 1'b1;
                            r_vec  <= '0;
                        end
                    end
                end
                default: begin
                    if (w_launch) begin
                        r_state   <= S_RUN;
                        r_page    <= page_lo;
                        r_page_hi <= page_hi;
                        r_vec     <= '0;
                        r_hold    <= '0;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                    end
                end
            endcase
        end
    end

    cell_sweep_sig u_sig (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (w_sample),
        .clear  (w_launch),
        .data   (cell_out),
        .sig    (sig)
    );

    assign page        = r_page;
    assign vec         = r_vec;
    assign busy        = r_busy;
    assign done        = r_done;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cell_sweep.sv
// Bench for cell_sweep: two instances (SETTLE=0 and SETTLE=2) driven by directed
// sweeps; completion monitors pop expected signature/busy length from queues.
module tb_cell_sweep;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    // ---------------- instance A: SETTLE = 0 ----------------
    logic       start_a = 1'b0, abort_a = 1'b0;
    logic [3:0] lo_a = '0, hi_a = '0, page_a;
    logic [5:0] vec_a;
    logic [7:0] cell_a, k_a = 8'h01;
    logic [1:0] mode_a = 2'd0, st_a;
    logic       busy_a, done_a;
    logic [15:0] sig_a;

    // ---------------- instance B: SETTLE = 2 ----------------
    logic       start_b = 1'b0, abort_b = 1'b0;
    logic [3:0] lo_b = '0, hi_b = '0, page_b;
    logic [5:0] vec_b;
    logic [7:0] cell_b, k_b = 8'h00;
    logic [1:0] mode_b = 2'd0, st_b;
    logic       busy_b, done_b;
    logic [15:0] sig_b;

    // cell_mux model: mode 0 returns a constant, mode 1 a page/vector pattern
    function automatic logic [7:0] mux_model(input logic [3:0] p, input logic [5:0] v,
                                             input logic [1:0] mode, input logic [7:0] k);
        if (mode == 2'd0) return k;
        return {p, 4'h0} ^ {2'b00, v} ^ 8'h5A;
    endfunction

    function automatic logic [15:0] upd(input logic [15:0] s, input logic [7:0] d);
`ifdef CELL_SWEEP_MISR_EN
        logic [15:0] sh;
        sh = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
        return sh ^ {8'h00, d};
`else
        return s + {8'h00, d};
`endif
    endfunction

    function automatic logic [15:0] ref_sig(input logic [3:0] lo, input int n,
                                            input logic [1:0] mode, input logic [7:0] k);
        logic [15:0] s;
        logic [3:0]  p;
        logic [5:0]  v;
        s = '0;
        for (int i = 0; i < n; i++) begin
            p = lo + 4'(i / 64);
            v = 6'(i % 64);
            s = upd(s, mux_model(p, v, mode, k));
        end
        return s;
    endfunction

    assign cell_a = mux_model(page_a, vec_a, mode_a, k_a);
    assign cell_b = mux_model(page_b, vec_b, mode_b, k_b);

    cell_sweep #(.SETTLE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .page_lo(lo_a), .page_hi(hi_a), .page(page_a), .vec(vec_a),
        .cell_out(cell_a), .busy(busy_a), .done(done_a), .sig(sig_a),
        .o_dbg_state(st_a)
    );

    cell_sweep #(.SETTLE(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .page_lo(lo_b), .page_hi(hi_b), .page(page_b), .vec(vec_b),
        .cell_out(cell_b), .busy(busy_b), .done(done_b), .sig(sig_b),
        .o_dbg_state(st_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got event/timeout expected none", name);
    endtask

    // ---------------- scoreboard ----------------
    logic [15:0] exp_sig_a_q[$];
    int          exp_len_a_q[$];
    logic [15:0] exp_sig_b_q[$];
    int          exp_len_b_q[$];
    int          cnt_a = 0, cnt_b = 0;
    logic        prev_busy_a = 1'b0, prev_busy_b = 1'b0;

    always @(negedge clk) begin
        if (busy_a) begin
            cnt_a++;
        end else begin
            if (prev_busy_a && done_a) begin
                if (exp_sig_a_q.size() == 0) begin
                    fail_now("sb_a_unexpected_done");
                end else begin
                    chk("sb_a_sig", 32'(sig_a), 32'(exp_sig_a_q.pop_front()));
                    chk("sb_a_busy_len", 32'(cnt_a), 32'(exp_len_a_q.pop_front()));
                end
            end
            cnt_a = 0;
        end
        prev_busy_a = busy_a;
    end

    always @(negedge clk) begin
        if (busy_b) begin
            cnt_b++;
        end else begin
            if (prev_busy_b && done_b) begin
                if (exp_sig_b_q.size() == 0) begin
                    fail_now("sb_b_unexpected_done");
                end else begin
                    chk("sb_b_sig", 32'(sig_b), 32'(exp_sig_b_q.pop_front()));
                    chk("sb_b_busy_len", 32'(cnt_b), 32'(exp_len_b_q.pop_front()));
                end
            end
            cnt_b = 0;
        end
        prev_busy_b = busy_b;
    end

    // ---------------- drivers ----------------
    // Pulses start for one cycle, then scrambles lo/hi to show they were latched.
    task automatic start_a_sweep(input logic [3:0] lo, input logic [3:0] hi);
        @(posedge clk);
        #1 lo_a = lo; hi_a = hi; start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0; lo_a = lo + 4'd7; hi_a = hi + 4'd3;
    endtask

    task automatic start_b_sweep(input logic [3:0] lo, input logic [3:0] hi);
        @(posedge clk);
        #1 lo_b = lo; hi_b = hi; start_b = 1'b1;
        @(posedge clk);
        #1 start_b = 1'b0; lo_b = lo + 4'd7; hi_b = hi + 4'd3;
    endtask

    task automatic wait_done_a(input int budget);
        int n = 0;
        while (!(done_a && !busy_a) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) fail_now("timeout_a");
    endtask

    task automatic wait_done_b(input int budget);
        int n = 0;
        while (!(done_b && !busy_b) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) fail_now("timeout_b");
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] wrap_pages[4];
        wrap_pages[0] = 4'd14; wrap_pages[1] = 4'd15;
        wrap_pages[2] = 4'd0;  wrap_pages[3] = 4'd1;

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_sig", 32'(sig_a), 32'd0);
        chk("rst_page_vec", {22'd0, page_a, vec_a}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_after_release", 32'(busy_a), 32'd0);

        // full sweep, constant response 1
        mode_a = 2'd0; k_a = 8'h01;
`ifdef CELL_SWEEP_MISR_EN
        exp_sig_a_q.push_back(ref_sig(4'd0, 1024, 2'd0, 8'h01));
`else
        exp_sig_a_q.push_back(16'h0400);
`endif
        exp_len_a_q.push_back(1024);
        start_a_sweep(4'd0, 4'd15);
        @(negedge clk);
        chk("full_busy_first", 32'(busy_a), 32'd1);
        chk("full_first_page_vec", {22'd0, page_a, vec_a}, 32'd0);
        wait_done_a(1100);
        chk("full_state_done", 32'(st_a), 32'd2);
        chk("full_done_page_vec", {22'd0, page_a, vec_a}, 32'd0);
        repeat (3) @(negedge clk);
        chk("done_sticky", 32'(done_a), 32'd1);

        // single page, SETTLE = 2, zero response
        mode_b = 2'd0; k_b = 8'h00;
        exp_sig_b_q.push_back(16'h0000);
        exp_len_b_q.push_back(192);
        start_b_sweep(4'd5, 4'd5);
        for (int i = 0; i < 192; i++) begin
            @(negedge clk);
            if (i % 48 == 0 || i == 191) chk("single_page", 32'(page_b), 32'd5);
            if (i % 40 == 1) chk("single_vec_hold", 32'(vec_b), 32'(i / 3));
        end
        wait_done_b(20);

        // wrap through 15 -> 0
        mode_a = 2'd0; k_a = 8'h01;
`ifdef CELL_SWEEP_MISR_EN
        exp_sig_a_q.push_back(ref_sig(4'd14, 256, 2'd0, 8'h01));
`else
        exp_sig_a_q.push_back(16'h0100);
`endif
        exp_len_a_q.push_back(256);
        start_a_sweep(4'd14, 4'd1);
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (i % 64 == 0 || i % 64 == 63)
                chk("wrap_page", 32'(page_a), 32'(wrap_pages[i / 64]));
        end
        wait_done_a(20);

        // patterned single page (bit-exact reference signature)
        mode_a = 2'd1;
        exp_sig_a_q.push_back(ref_sig(4'd0, 64, 2'd1, 8'h00));
        exp_len_a_q.push_back(64);
        start_a_sweep(4'd0, 4'd0);
        wait_done_a(100);

        // abort together with start, from DONE
        @(posedge clk);
        #1 start_a = 1'b1; abort_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0; abort_a = 1'b0;
        @(negedge clk);
        chk("abort_start_state", 32'(st_a), 32'd0);
        chk("abort_start_done", 32'(done_a), 32'd0);
        chk("abort_start_busy", 32'(busy_a), 32'd0);

        // abort at cycle 100 with an ignored start pulse in the middle
        mode_a = 2'd1;
        start_a_sweep(4'd0, 4'd15);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i == 50) begin start_a = 1'b1; lo_a = 4'd9; end
            if (i == 51) start_a = 1'b0;
            if (i == 60) chk("run_start_ignored", {22'd0, page_a, vec_a}, {22'd0, 4'd0, 6'd60});
            if (i == 70) chk("run_page_adv", {22'd0, page_a, vec_a}, {22'd0, 4'd1, 6'd6});
        end
        @(posedge clk);
        #1 abort_a = 1'b1;
        @(posedge clk);
        #1 abort_a = 1'b0;
        @(negedge clk);
        chk("abort_busy_done", {30'd0, busy_a, done_a}, 32'd0);
        chk("abort_page_vec", {22'd0, page_a, vec_a}, 32'd0);
        chk("abort_sig_kept", 32'(sig_a), 32'(ref_sig(4'd0, 100, 2'd1, 8'h00)));
        repeat (4) @(negedge clk);
        chk("abort_stays_idle", {30'd0, busy_a, st_a == 2'd0}, 32'd1);

        // asynchronous reset mid-sweep, then a normal full sweep
        mode_a = 2'd0; k_a = 8'h01;
        start_a_sweep(4'd0, 4'd15);
        repeat (300) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy_done", {30'd0, busy_a, done_a}, 32'd0);
        chk("arst_page_vec", {22'd0, page_a, vec_a}, 32'd0);
        chk("arst_sig", 32'(sig_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("no_sweep_after_rst", {30'd0, busy_a, st_a != 2'd0}, 32'd0);
`ifdef CELL_SWEEP_MISR_EN
        exp_sig_a_q.push_back(ref_sig(4'd0, 1024, 2'd0, 8'h01));
`else
        exp_sig_a_q.push_back(16'h0400);
`endif
        exp_len_a_q.push_back(1024);
        start_a_sweep(4'd0, 4'd15);
        wait_done_a(1100);

        repeat (4) @(negedge clk);
        chk("sb_a_drained", 32'(exp_sig_a_q.size()), 32'd0);
        chk("sb_b_drained", 32'(exp_sig_b_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
